// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   - arb_state_e : one-hot arbiter state (IDLE / BUSY_IF / BUSY_LS)
//   - REQ_IF/REQ_LS : requester identifiers, also the encoding of last_grant
//   - mem_req_t   : one captured memory request {ren, wen, addr, wMask, wData}
//   - req_zero()  : an all-zero request, used as the idle value
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 64;
  localparam int ARB_MASK_W = ARB_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    BUSY_IF = 3'b010,
    BUSY_LS = 3'b100
  } arb_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  typedef struct packed {
    logic                  ren;
    logic                  wen;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_MASK_W-1:0] wMask;
    logic [ARB_DATA_W-1:0] wData;
  } mem_req_t;

  function automatic mem_req_t req_zero();
    mem_req_t r;
    r.ren   = 1'b0;
    r.wen   = 1'b0;
    r.addr  = {ARB_ADDR_W{1'b0}};
    r.wMask = {ARB_MASK_W{1'b0}};
    r.wData = {ARB_DATA_W{1'b0}};
    return r;
  endfunction

endpackage

// File: rtl/mem_req_buf.sv
// One-entry pending-request buffer for one requester of the arbiter.
// Ports:
//   clock, reset : clock and synchronous active-high reset (empties the entry)
//   cap          : capture req_in this cycle (ignored while the entry is full)
//   clr          : the entry is being issued this cycle; empties it
//   req_in       : request to capture
//   valid        : entry holds a request
//   req_out      : the stored request
module mem_req_buf
  import mem_arb_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     cap,
  input  logic     clr,
  input  mem_req_t req_in,
  output logic     valid,
  output mem_req_t req_out
);

  logic     valid_q, valid_d;
  mem_req_t req_q, req_d;

  // Next entry: clear wins; a capture into a full entry is dropped.
  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (cap && !valid_q) begin
      valid_d = 1'b1;
      req_d   = req_in;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      req_q   <= req_zero();
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign valid   = valid_q;
  assign req_out = req_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single memory port between the instruction-fetch (IF)
// and load/store (LS) requesters. One transaction is outstanding at a time.
// A lone request arriving with nothing pending is forwarded combinationally;
// otherwise requests wait in a per-requester one-entry buffer and issue from
// it one cycle later. LS wins simultaneous arrival, and when both buffers are
// full the requester that was not granted last goes first.
// Ports:
//   clock, reset                      : clock, synchronous active-high reset
//   if_ren, if_addr                   : IF read request pulse and address
//   if_rData, if_hit, if_rvalid       : IF response (hit = same-cycle done)
//   ls_ren, ls_wen, ls_addr,
//   ls_wMask, ls_wData                : LS request pulse (both high = write)
//   ls_rData, ls_hit, ls_rvalid       : LS response
//   mem_ren, mem_wen, mem_addr,
//   mem_wMask, mem_wData              : downstream request pulse
//   mem_rData, mem_hit, mem_rvalid    : downstream response
// The request struct is sized from mem_arb_pkg; the parameters must match it.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int MASK_W = ARB_MASK_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_ren,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rData,
  output logic              if_hit,
  output logic              if_rvalid,
  input  logic              ls_ren,
  input  logic              ls_wen,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [MASK_W-1:0] ls_wMask,
  input  logic [DATA_W-1:0] ls_wData,
  output logic [DATA_W-1:0] ls_rData,
  output logic              ls_hit,
  output logic              ls_rvalid,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MASK_W-1:0] mem_wMask,
  output logic [DATA_W-1:0] mem_wData,
  input  logic [DATA_W-1:0] mem_rData,
  input  logic              mem_hit,
  input  logic              mem_rvalid
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       blank_q, blank_d;

  mem_req_t if_new, ls_new, if_pend, ls_pend, issue_req;
  logic     if_pulse, ls_pulse;
  logic     if_pend_v, ls_pend_v;
  logic     if_cap, ls_cap, if_clr, ls_clr;
  logic     issue_v, issue_id;

  // Package the incoming pulses as requests; LS ren+wen together is a write.
  always_comb begin
    if_pulse     = if_ren;
    ls_pulse     = ls_ren | ls_wen;
    if_new       = req_zero();
    if_new.ren   = if_ren;
    if_new.addr  = if_addr;
    ls_new       = req_zero();
    ls_new.ren   = ls_ren & ~ls_wen;
    ls_new.wen   = ls_wen;
    ls_new.addr  = ls_addr;
    ls_new.wMask = ls_wMask;
    ls_new.wData = ls_wData;
  end

  mem_req_buf u_if_buf (
    .clock   (clock),
    .reset   (reset),
    .cap     (if_cap),
    .clr     (if_clr),
    .req_in  (if_new),
    .valid   (if_pend_v),
    .req_out (if_pend)
  );

  mem_req_buf u_ls_buf (
    .clock   (clock),
    .reset   (reset),
    .cap     (ls_cap),
    .clr     (ls_clr),
    .req_in  (ls_new),
    .valid   (ls_pend_v),
    .req_out (ls_pend)
  );

  // Grant selection, buffer control, downstream request and response routing.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    blank_d      = 1'b0;
    if_cap       = 1'b0;
    ls_cap       = 1'b0;
    if_clr       = 1'b0;
    ls_clr       = 1'b0;
    issue_v      = 1'b0;
    issue_id     = REQ_IF;
    issue_req    = req_zero();
    mem_ren      = 1'b0;
    mem_wen      = 1'b0;
    mem_addr     = {ADDR_W{1'b0}};
    mem_wMask    = {MASK_W{1'b0}};
    mem_wData    = {DATA_W{1'b0}};
    if_hit       = 1'b0;
    if_rvalid    = 1'b0;
    if_rData     = {DATA_W{1'b0}};
    ls_hit       = 1'b0;
    ls_rvalid    = 1'b0;
    ls_rData     = {DATA_W{1'b0}};

    // Inputs are ignored, and outputs held at zero, during reset and the
    // cycle that follows it.
    if (!reset && !blank_q) begin
      case (state_q)
        IDLE: begin
          if (if_pend_v || ls_pend_v) begin
            // Buffered work goes first; new pulses only get captured.
            issue_v = 1'b1;
            if (if_pend_v && ls_pend_v) begin
              issue_id = ~last_grant_q;
            end else if (ls_pend_v) begin
              issue_id = REQ_LS;
            end else begin
              issue_id = REQ_IF;
            end
            if (issue_id == REQ_LS) begin
              issue_req = ls_pend;
              ls_clr    = 1'b1;
            end else begin
              issue_req = if_pend;
              if_clr    = 1'b1;
            end
            if_cap = if_pulse;
            ls_cap = ls_pulse;
          end else if (ls_pulse) begin
            issue_v   = 1'b1;
            issue_id  = REQ_LS;
            issue_req = ls_new;
            if_cap    = if_pulse;
          end else if (if_pulse) begin
            issue_v   = 1'b1;
            issue_id  = REQ_IF;
            issue_req = if_new;
          end else begin
            issue_v = 1'b0;
          end
        end
        BUSY_IF: begin
          // The owner may re-request in its own completion cycle.
          if_cap = if_pulse & mem_rvalid;
          ls_cap = ls_pulse;
          if (mem_rvalid) begin
            if_rvalid    = 1'b1;
            if_rData     = mem_rData;
            last_grant_d = REQ_IF;
            state_d      = IDLE;
          end else begin
            state_d = BUSY_IF;
          end
        end
        BUSY_LS: begin
          if_cap = if_pulse;
          ls_cap = ls_pulse & mem_rvalid;
          if (mem_rvalid) begin
            ls_rvalid    = 1'b1;
            ls_rData     = mem_rData;
            last_grant_d = REQ_LS;
            state_d      = IDLE;
          end else begin
            state_d = BUSY_LS;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (issue_v) begin
        mem_ren   = issue_req.ren;
        mem_wen   = issue_req.wen;
        mem_addr  = issue_req.addr;
        mem_wMask = issue_req.wMask;
        mem_wData = issue_req.wData;
        if (mem_hit) begin
          last_grant_d = issue_id;
          if (issue_id == REQ_LS) begin
            ls_hit   = 1'b1;
            ls_rData = mem_rData;
          end else begin
            if_hit   = 1'b1;
            if_rData = mem_rData;
          end
        end else begin
          state_d = (issue_id == REQ_LS) ? BUSY_LS : BUSY_IF;
        end
      end else begin
        issue_req = req_zero();
      end
    end else begin
      blank_d = 1'b0;
    end
  end

  // State, fairness bit and post-reset blanking flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_IF;
      blank_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      blank_q      <= blank_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_ren;
  logic [31:0] if_addr;
  logic [63:0] if_rData;
  logic        if_hit, if_rvalid;
  logic        ls_ren, ls_wen;
  logic [31:0] ls_addr;
  logic [7:0]  ls_wMask;
  logic [63:0] ls_wData;
  logic [63:0] ls_rData;
  logic        ls_hit, ls_rvalid;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wMask;
  logic [63:0] mem_wData;
  logic [63:0] mem_rData;
  logic        mem_hit, mem_rvalid;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [63:0] NOISE = 64'hDEAD_BEEF_0BAD_F00D;

  mem_arbiter dut (
    .clock(clk), .reset(reset),
    .if_ren(if_ren), .if_addr(if_addr), .if_rData(if_rData),
    .if_hit(if_hit), .if_rvalid(if_rvalid),
    .ls_ren(ls_ren), .ls_wen(ls_wen), .ls_addr(ls_addr),
    .ls_wMask(ls_wMask), .ls_wData(ls_wData), .ls_rData(ls_rData),
    .ls_hit(ls_hit), .ls_rvalid(ls_rvalid),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wMask(mem_wMask), .mem_wData(mem_wData), .mem_rData(mem_rData),
    .mem_hit(mem_hit), .mem_rvalid(mem_rvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] ctrl();
    return {mem_ren, mem_wen, if_hit, if_rvalid, ls_hit, ls_rvalid};
  endfunction

  task automatic idle_inputs();
    reset = 1'b0; if_ren = 1'b0; if_addr = 32'h0;
    ls_ren = 1'b0; ls_wen = 1'b0; ls_addr = 32'h0; ls_wMask = 8'h0; ls_wData = 64'h0;
    mem_hit = 1'b0; mem_rvalid = 1'b0; mem_rData = NOISE;
  endtask

  // Reset with live inputs, then the blanking cycle, then a quiet cycle.
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      reset = (i < 2);
      if (i < 3) begin
        if_ren = 1'b1; if_addr = 32'h8000_0000; ls_wen = 1'b1; ls_addr = 32'h1234_5678;
        ls_wMask = 8'hFF; ls_wData = 64'h1; mem_hit = 1'b1; mem_rvalid = 1'b1;
      end
      #2;
      n_chk++;
      if ({ctrl(), mem_addr, mem_wMask, mem_wData, if_rData, ls_rData} !== 238'h0) begin
        n_fail++;
        $display("FAIL reset_quiet cyc%0d: ctrl=%b addr=%h ifd=%h lsd=%h required all zero",
                 i, ctrl(), mem_addr, if_rData, ls_rData);
      end
    end
  endtask

  // Same-cycle hit on an IF read, a stray rvalid, then another immediate hit.
  task automatic test_if_hit();
    logic [5:0] ec; logic [31:0] ea; logic [63:0] eir;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      ec = 6'b0; ea = 32'h0; eir = 64'h0;
      case (i)
        0: begin if_ren = 1'b1; if_addr = 32'h8000_0000; mem_hit = 1'b1;
             mem_rData = 64'h0123_4567_89AB_CDEF; ec = 6'b101000; ea = 32'h8000_0000;
             eir = 64'h0123_4567_89AB_CDEF; end
        1: begin mem_rvalid = 1'b1; end
        2: begin if_ren = 1'b1; if_addr = 32'h8000_0040; mem_hit = 1'b1;
             mem_rData = 64'h55; ec = 6'b101000; ea = 32'h8000_0040; eir = 64'h55; end
        default: ;
      endcase
      #2;
      n_chk++; if (ctrl() !== ec) begin n_fail++; $display("FAIL if_hit_ctrl cyc%0d: got %b want %b", i, ctrl(), ec); end
      n_chk++; if (mem_addr !== ea) begin n_fail++; $display("FAIL if_hit_addr cyc%0d: got %h want %h", i, mem_addr, ea); end
      n_chk++; if (if_rData !== eir) begin n_fail++; $display("FAIL if_hit_rdata cyc%0d: got %h want %h", i, if_rData, eir); end
      n_chk++; if (ls_rData !== 64'h0) begin n_fail++; $display("FAIL if_hit_lsdata cyc%0d: got %h want 0", i, ls_rData); end
    end
  endtask

  // LS write miss acknowledged by rvalid three cycles later.
  task automatic test_ls_write();
    logic [5:0] ec; logic [31:0] ea; logic [7:0] em; logic [63:0] ed, elr;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_inputs();
      ec = 6'b0; ea = 32'h0; em = 8'h0; ed = 64'h0; elr = 64'h0;
      case (i)
        0: begin ls_wen = 1'b1; ls_addr = 32'h8000_1000; ls_wMask = 8'h0F;
             ls_wData = 64'h1122_3344_5566_7788; ec = 6'b010000; ea = 32'h8000_1000;
             em = 8'h0F; ed = 64'h1122_3344_5566_7788; end
        3: begin mem_rvalid = 1'b1; mem_rData = 64'h77; ec = 6'b000001; elr = 64'h77; end
        default: ;
      endcase
      #2;
      n_chk++; if (ctrl() !== ec) begin n_fail++; $display("FAIL ls_wr_ctrl cyc%0d: got %b want %b", i, ctrl(), ec); end
      n_chk++; if ({mem_addr, mem_wMask, mem_wData} !== {ea, em, ed}) begin n_fail++;
        $display("FAIL ls_wr_req cyc%0d: got %h/%h/%h want %h/%h/%h", i, mem_addr, mem_wMask, mem_wData, ea, em, ed); end
      n_chk++; if (ls_rData !== elr || if_rData !== 64'h0) begin n_fail++;
        $display("FAIL ls_wr_rdata cyc%0d: ls=%h if=%h want ls=%h if=0", i, ls_rData, if_rData, elr); end
    end
  endtask

  // Both request in one cycle; LS first, IF from buffer after LS completes.
  task automatic test_both_same_cycle();
    logic [5:0] ec; logic [31:0] ea; logic [63:0] eir, elr;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_inputs();
      ec = 6'b0; ea = 32'h0; eir = 64'h0; elr = 64'h0;
      case (i)
        0: begin if_ren = 1'b1; if_addr = 32'h8000_2000; ls_ren = 1'b1; ls_addr = 32'h8000_3000;
             ec = 6'b100000; ea = 32'h8000_3000; end
        2: begin mem_rvalid = 1'b1; mem_rData = {4{16'hAAAA}}; ec = 6'b000001; elr = {4{16'hAAAA}}; end
        3: begin ec = 6'b100000; ea = 32'h8000_2000; end
        5: begin mem_rvalid = 1'b1; mem_rData = {4{16'hBBBB}}; ec = 6'b000100; eir = {4{16'hBBBB}}; end
        default: ;
      endcase
      #2;
      n_chk++; if (ctrl() !== ec) begin n_fail++; $display("FAIL both_ctrl cyc%0d: got %b want %b", i, ctrl(), ec); end
      n_chk++; if (mem_addr !== ea) begin n_fail++; $display("FAIL both_addr cyc%0d: got %h want %h", i, mem_addr, ea); end
      n_chk++; if (if_rData !== eir || ls_rData !== elr) begin n_fail++;
        $display("FAIL both_rdata cyc%0d: if=%h ls=%h want if=%h ls=%h", i, if_rData, ls_rData, eir, elr); end
    end
  endtask

  // IF arriving while LS is outstanding waits in the buffer.
  task automatic test_if_while_busy_ls();
    logic [5:0] ec; logic [31:0] ea; logic [63:0] eir, elr;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_inputs();
      ec = 6'b0; ea = 32'h0; eir = 64'h0; elr = 64'h0;
      case (i)
        0: begin ls_ren = 1'b1; ls_addr = 32'h8000_6000; ec = 6'b100000; ea = 32'h8000_6000; end
        1: begin if_ren = 1'b1; if_addr = 32'h8000_7000; end
        3: begin mem_rvalid = 1'b1; mem_rData = 64'h31; ec = 6'b000001; elr = 64'h31; end
        4: begin ec = 6'b100000; ea = 32'h8000_7000; end
        5: begin mem_rvalid = 1'b1; mem_rData = 64'h42; ec = 6'b000100; eir = 64'h42; end
        default: ;
      endcase
      #2;
      n_chk++; if (ctrl() !== ec) begin n_fail++; $display("FAIL busy_ctrl cyc%0d: got %b want %b", i, ctrl(), ec); end
      n_chk++; if (mem_addr !== ea) begin n_fail++; $display("FAIL busy_addr cyc%0d: got %h want %h", i, mem_addr, ea); end
      n_chk++; if (if_rData !== eir || ls_rData !== elr) begin n_fail++;
        $display("FAIL busy_rdata cyc%0d: if=%h ls=%h want if=%h ls=%h", i, if_rData, ls_rData, eir, elr); end
    end
  endtask

  // Reset one cycle after an IF miss: the late rvalid must produce nothing.
  task automatic test_reset_mid();
    logic [5:0] ec; logic [31:0] ea; logic [63:0] elr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_inputs();
      ec = 6'b0; ea = 32'h0; elr = 64'h0;
      case (i)
        0: begin if_ren = 1'b1; if_addr = 32'h8000_4000; ec = 6'b100000; ea = 32'h8000_4000; end
        1: begin reset = 1'b1; mem_rvalid = 1'b1; end
        2: begin mem_rvalid = 1'b1; end
        3: begin mem_rvalid = 1'b1; end
        4: begin ls_ren = 1'b1; ls_addr = 32'h8000_5000; mem_hit = 1'b1; mem_rData = 64'h99;
             ec = 6'b100010; ea = 32'h8000_5000; elr = 64'h99; end
        default: ;
      endcase
      #2;
      n_chk++; if (ctrl() !== ec) begin n_fail++; $display("FAIL rstmid_ctrl cyc%0d: got %b want %b", i, ctrl(), ec); end
      n_chk++; if (mem_addr !== ea) begin n_fail++; $display("FAIL rstmid_addr cyc%0d: got %h want %h", i, mem_addr, ea); end
      n_chk++; if (ls_rData !== elr || if_rData !== 64'h0) begin n_fail++;
        $display("FAIL rstmid_rdata cyc%0d: ls=%h if=%h want ls=%h if=0", i, ls_rData, if_rData, elr); end
    end
  endtask

  // Both buffered at IDLE right after an LS completion: IF must win.
  task automatic test_fairness();
    logic [5:0] ec; logic [31:0] ea; logic [7:0] em; logic [63:0] ed, eir, elr;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      idle_inputs();
      ec = 6'b0; ea = 32'h0; em = 8'h0; ed = 64'h0; eir = 64'h0; elr = 64'h0;
      case (i)
        0: begin ls_ren = 1'b1; ls_addr = 32'h8000_8000; ec = 6'b100000; ea = 32'h8000_8000; end
        1: begin if_ren = 1'b1; if_addr = 32'h8000_9000; end
        2: begin mem_rvalid = 1'b1; mem_rData = 64'h11; ec = 6'b000001; elr = 64'h11;
             ls_wen = 1'b1; ls_addr = 32'h8000_A000; ls_wMask = 8'hF0; ls_wData = 64'hFEED; end
        3: begin ec = 6'b100000; ea = 32'h8000_9000; end
        4: begin mem_rvalid = 1'b1; mem_rData = 64'h22; ec = 6'b000100; eir = 64'h22; end
        5: begin ec = 6'b010000; ea = 32'h8000_A000; em = 8'hF0; ed = 64'hFEED; end
        6: begin mem_rvalid = 1'b1; mem_rData = 64'h33; ec = 6'b000001; elr = 64'h33; end
        default: ;
      endcase
      #2;
      n_chk++; if (ctrl() !== ec) begin n_fail++; $display("FAIL fair_ctrl cyc%0d: got %b want %b", i, ctrl(), ec); end
      n_chk++; if ({mem_addr, mem_wMask, mem_wData} !== {ea, em, ed}) begin n_fail++;
        $display("FAIL fair_req cyc%0d: got %h/%h/%h want %h/%h/%h", i, mem_addr, mem_wMask, mem_wData, ea, em, ed); end
      n_chk++; if (if_rData !== eir || ls_rData !== elr) begin n_fail++;
        $display("FAIL fair_rdata cyc%0d: if=%h ls=%h want if=%h ls=%h", i, if_rData, ls_rData, eir, elr); end
    end
  endtask

  // Random traffic against a transaction-level model: owner of the port,
  // a one-deep queue per requester, and who was served last.
  task automatic test_random();
    int owner, last, g;
    logic blank, fb, is_w;
    logic pv[2], pw[2], nw[2], nwr[2], acc[2], e_hit[2], e_rv[2];
    logic [31:0] pa[2], na[2];
    logic [7:0]  pm[2], nm[2];
    logic [63:0] pd[2], nd[2], e_rd[2];
    logic        e_mr, e_mw;
    logic [31:0] e_a;
    logic [7:0]  e_m;
    logic [63:0] e_d;
    logic [5:0]  ec;
    owner = -1; last = 0; blank = 1'b1;
    for (int r = 0; r < 2; r++) begin pv[r] = 1'b0; pw[r] = 1'b0; pa[r] = 32'h0; pm[r] = 8'h0; pd[r] = 64'h0; end
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      idle_inputs();
      reset      = (i == 0) || ($urandom_range(0, 99) < 2);
      mem_hit    = ($urandom_range(0, 2) == 0);
      mem_rvalid = ($urandom_range(0, 3) == 0);
      mem_rData  = {$urandom, $urandom};
      if_addr    = $urandom;
      ls_addr    = $urandom;
      ls_wMask   = 8'($urandom);
      ls_wData   = {$urandom, $urandom};
      // A requester may issue only when it has nothing outstanding.
      if (!pv[0] && (owner != 0 || mem_rvalid)) if_ren = ($urandom_range(0, 2) == 0);
      if (!pv[1] && (owner != 1 || mem_rvalid)) begin
        case ($urandom_range(0, 5))
          0: ls_ren = 1'b1;
          1: ls_wen = 1'b1;
          2: begin ls_ren = 1'b1; ls_wen = 1'b1; end
          default: ;
        endcase
      end
      #2;
      e_mr = 1'b0; e_mw = 1'b0; e_a = 32'h0; e_m = 8'h0; e_d = 64'h0;
      for (int r = 0; r < 2; r++) begin e_hit[r] = 1'b0; e_rv[r] = 1'b0; e_rd[r] = 64'h0; end
      if (reset) begin
        owner = -1; last = 0; blank = 1'b1; pv[0] = 1'b0; pv[1] = 1'b0;
      end else if (blank) begin
        blank = 1'b0;
      end else begin
        nw[0] = if_ren; na[0] = if_addr; nwr[0] = 1'b0; nm[0] = 8'h0; nd[0] = 64'h0;
        nw[1] = ls_ren | ls_wen; na[1] = ls_addr; nwr[1] = ls_wen; nm[1] = ls_wMask; nd[1] = ls_wData;
        g = -1; fb = 1'b0;
        if (owner < 0) begin
          if (pv[0] || pv[1]) begin
            fb = 1'b1;
            g  = (pv[0] && pv[1]) ? 1 - last : (pv[1] ? 1 : 0);
          end else if (nw[1]) g = 1;
          else if (nw[0]) g = 0;
        end
        for (int r = 0; r < 2; r++)
          acc[r] = nw[r] && !pv[r] && !(g == r && !fb) && !(owner == r && !mem_rvalid);
        if (g >= 0) begin
          is_w = fb ? pw[g] : nwr[g];
          e_mr = !is_w; e_mw = is_w;
          e_a  = fb ? pa[g] : na[g];
          e_m  = fb ? pm[g] : nm[g];
          e_d  = fb ? pd[g] : nd[g];
          if (fb) pv[g] = 1'b0;
          if (mem_hit) begin e_hit[g] = 1'b1; e_rd[g] = mem_rData; last = g; end
          else owner = g;
        end else if (owner >= 0 && mem_rvalid) begin
          e_rv[owner] = 1'b1; e_rd[owner] = mem_rData; last = owner; owner = -1;
        end
        for (int r = 0; r < 2; r++)
          if (acc[r]) begin pv[r] = 1'b1; pw[r] = nwr[r]; pa[r] = na[r]; pm[r] = nm[r]; pd[r] = nd[r]; end
      end
      ec = {e_mr, e_mw, e_hit[0], e_rv[0], e_hit[1], e_rv[1]};
      n_chk++; if (ctrl() !== ec) begin n_fail++; $display("FAIL rnd_ctrl cyc%0d: got %b want %b", i, ctrl(), ec); end
      n_chk++; if ({mem_addr, mem_wMask, mem_wData} !== {e_a, e_m, e_d}) begin n_fail++;
        $display("FAIL rnd_req cyc%0d: got %h/%h/%h want %h/%h/%h", i, mem_addr, mem_wMask, mem_wData, e_a, e_m, e_d); end
      n_chk++; if (if_rData !== e_rd[0]) begin n_fail++; $display("FAIL rnd_if_rdata cyc%0d: got %h want %h", i, if_rData, e_rd[0]); end
      n_chk++; if (ls_rData !== e_rd[1]) begin n_fail++; $display("FAIL rnd_ls_rdata cyc%0d: got %h want %h", i, ls_rData, e_rd[1]); end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_if_hit();
    test_ls_write();
    test_both_same_cycle();
    test_if_while_busy_ls();
    test_reset_mid();
    test_fairness();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
